// File: rtl/sdr_wb_arbiter.sv
// ---------------------------------------------------------------------------
// sdr_wb_arbiter
//
// Shares the single Wishbone slave port of the SDRAM controller between
// NUM_M bus masters. A master is granted for a whole Wishbone cycle. The
// grant is held until that master drops cyc, so bursts are never broken up.
// The granted master's request is muxed onto the s_* port. Ack is routed back
// to that master only.
//
// Arbitration is round-robin by default: the last winner gets the lowest
// priority at the next arbitration. When the macro SDR_ARB_PRIO_EN is
// defined, fixed priority is used instead: the lowest requesting index wins.
//
// Ports
//   sys_clk, RESETN          Wishbone clock; synchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i   per-master strobes          [NUM_M]
//   m_addr_i                 packed addresses            [NUM_M*AW]
//   m_dat_i                  packed write data           [NUM_M*DW]
//   m_sel_i                  packed byte selects         [NUM_M*DW/8]
//   m_cti_i                  packed cycle type ids       [NUM_M*3]
//   m_ack_o                  per-master ack (granted bit only)
//   m_dat_o                  read data broadcast (s_dat_i pass-through)
//   s_*                      towards the controller wb_* port
//   grant_o                  registered one-hot grant, 0 when idle
// ---------------------------------------------------------------------------
module sdr_wb_arbiter #(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                    sys_clk,
    input  logic                    RESETN,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*AW-1:0]     m_addr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]      m_cti_i,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [DW-1:0]           m_dat_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_addr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic [2:0]              s_cti_o,
    input  logic                    s_ack_i,
    input  logic [DW-1:0]           s_dat_i,
    output logic [NUM_M-1:0]        grant_o
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = DW / 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IW-1:0]    win_idx;
    logic             own_cyc;

`ifdef SDR_ARB_PRIO_EN
    function automatic logic [IW-1:0] pick_prio(input logic [NUM_M-1:0] req);
        logic [IW-1:0] idx;
        idx = '0;
        // Walk downwards so the lowest requesting index is the final write.
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    assign win_idx = pick_prio(m_cyc_i);
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    // Search starts just after the last winner, wrapping modulo NUM_M,
    // so the last winner is the final candidate considered.
    function automatic logic [IW-1:0] pick_rr(input logic [IW-1:0]    ptr,
                                              input logic [NUM_M-1:0] req);
        logic [IW-1:0] idx;
        logic          found;
        int            c;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            c = (int'(ptr) + i) % NUM_M;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
        return idx;
    endfunction

    assign win_idx = pick_rr(rr_ptr_q, m_cyc_i);
`endif

    assign own_cyc = |(m_cyc_i & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef SDR_ARB_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // stb is not needed to win; cyc alone requests the bus.
                if (|m_cyc_i) begin
                    state_d          = OWN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
`ifndef SDR_ARB_PRIO_EN
                    rr_ptr_d         = win_idx;
`endif
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs stay 0 in IDLE, which guarantees the controller sees at least
    // one idle cycle between owners and that a stray s_ack_i is swallowed.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m_ack_o  = '0;
        if (state_q == OWN) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (grant_q[k]) begin
                    s_cyc_o  = m_cyc_i[k];
                    s_stb_o  = m_stb_i[k];
                    s_we_o   = m_we_i[k];
                    s_addr_o = m_addr_i[k*AW +: AW];
                    s_dat_o  = m_dat_i[k*DW +: DW];
                    s_sel_o  = m_sel_i[k*SW +: SW];
                    s_cti_o  = m_cti_i[k*3 +: 3];
                end
            end
            m_ack_o = grant_q & m_cyc_i & {NUM_M{s_ack_i}};
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            grant_q  <= '0;
`ifndef SDR_ARB_PRIO_EN
            // First arbitration after reset then starts its search at master 0.
            rr_ptr_q <= IW'(NUM_M - 1);
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
`ifndef SDR_ARB_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
module tb_sdr_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic        hold;
    } op_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] dat;
    } sb_t;

    logic        clk = 1'b0;
    logic        RESETN;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_addr, m_dat;
    logic [7:0]  m_sel;
    logic [5:0]  m_cti;
    logic [1:0]  m_ack_o;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;

    logic        sl_ack = 1'b0;
    logic [31:0] sl_dat = 32'h0;
    logic        stray  = 1'b0;
    logic [31:0] mem [0:1023];

    op_t  mq0[$], mq1[$];
    sb_t  sb0[$], sb1[$];
    op_t  cur[2];
    logic [1:0] busy = '0, keep = '0;
    logic abort = 1'b0;
    logic mon_en = 1'b0;
    logic [1:0] prev_g = '0;
    int   glog[$];
    int   grant_cyc[2], cyc_rise[2], cyc_fall[2], ack_cnt[2];
    int   cyc_n = 0;
    int   n_checks = 0, n_pass = 0;

    assign s_ack_i = sl_ack | stray;
    assign s_dat_i = sl_dat;

    sdr_wb_arbiter #(.NUM_M(2), .AW(32), .DW(32)) dut (
        .sys_clk (clk),     .RESETN  (RESETN),
        .m_cyc_i (m_cyc),   .m_stb_i (m_stb),   .m_we_i  (m_we),
        .m_addr_i(m_addr),  .m_dat_i (m_dat),   .m_sel_i (m_sel),
        .m_cti_i (m_cti),   .m_ack_o (m_ack_o), .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o  (s_we_o),
        .s_addr_o(s_addr_o),.s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_cti_o (s_cti_o), .s_ack_i (s_ack_i), .s_dat_i (s_dat_i),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic chk(input string name, input logic ok);
        n_checks++;
        if (ok === 1'b1) n_pass++;
        else $display("FAIL %s: condition false (cycle %0d)", name, cyc_n);
    endtask

    // Simple SDRAM stand-in: one registered ack per strobe, memory not reset.
    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && !sl_ack) begin
            sl_ack <= 1'b1;
            if (s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel_o[b]) mem[s_addr_o[11:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end else begin
                sl_dat <= mem[s_addr_o[11:2]];
            end
        end else begin
            sl_ack <= 1'b0;
        end
    end

    // Master engine: both masters modelled in one process.
    initial begin : engine
        logic [1:0] ack_s, new_cyc;
        logic skip;
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
        forever begin
            @(negedge clk);
            ack_s = m_ack_o;
            @(posedge clk);
            #1;
            if (abort) begin
                busy = '0; keep = '0; mq0.delete(); mq1.delete(); abort = 1'b0;
                ack_s = '0;
            end
            for (int k = 0; k < 2; k++) begin
                skip = 1'b0;
                if (busy[k] && ack_s[k]) begin
                    busy[k] = 1'b0;
                    if (!cur[k].hold) begin keep[k] = 1'b0; skip = 1'b1; end
                end
                if (!busy[k] && !skip) begin
                    if (k == 0 && mq0.size() != 0) begin
                        cur[0] = mq0.pop_front(); busy[0] = 1'b1; keep[0] = cur[0].hold;
                    end
                    if (k == 1 && mq1.size() != 0) begin
                        cur[1] = mq1.pop_front(); busy[1] = 1'b1; keep[1] = cur[1].hold;
                    end
                end
            end
            new_cyc = busy | keep;
            for (int k = 0; k < 2; k++) begin
                if (new_cyc[k] && !m_cyc[k]) cyc_rise[k] = cyc_n;
                if (!new_cyc[k] && m_cyc[k]) cyc_fall[k] = cyc_n;
                m_we[k]           = busy[k] & cur[k].we;
                m_addr[k*32 +: 32] = busy[k] ? cur[k].addr : 32'h0;
                m_dat[k*32 +: 32]  = busy[k] ? cur[k].dat  : 32'h0;
                m_sel[k*4 +: 4]    = busy[k] ? cur[k].sel  : 4'h0;
                m_cti[k*3 +: 3]    = busy[k] ? cur[k].cti  : 3'h0;
            end
            m_cyc = new_cyc;
            m_stb = busy;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            int gi;
            sb_t e;
            gi = grant_o[1] ? 1 : 0;
            chk_eq("ack_outside_grant", {62'h0, m_ack_o & ~grant_o}, 64'h0);
            chk_eq("grant_onehot0", {63'h0, $onehot0(grant_o)}, 64'h1);
            chk_eq("dat_passthru", {32'h0, m_dat_o}, {32'h0, s_dat_i});
            if (grant_o == 2'b00) begin
                chk_eq("idle_s_zero", {61'h0, s_cyc_o, s_stb_o, s_we_o}, 64'h0);
            end else begin
                chk_eq("own_s_cyc", {63'h0, s_cyc_o}, {63'h0, m_cyc[gi]});
                chk_eq("own_s_addr", {32'h0, s_addr_o}, {32'h0, m_addr[gi*32 +: 32]});
                chk_eq("own_s_cti", {61'h0, s_cti_o}, {61'h0, m_cti[gi*3 +: 3]});
                if (prev_g != 2'b00) chk_eq("grant_no_switch", {62'h0, grant_o}, {62'h0, prev_g});
                else begin
                    glog.push_back(gi);
                    grant_cyc[gi] = cyc_n;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (m_ack_o[k]) begin
                    ack_cnt[k]++;
                    chk($sformatf("ack_expected_m%0d", k), (k == 0) ? (sb0.size() != 0) : (sb1.size() != 0));
                    if ((k == 0 && sb0.size() != 0) || (k == 1 && sb1.size() != 0)) begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        if (e.rd) chk_eq($sformatf("rd_data_m%0d", k), {32'h0, m_dat_o}, {32'h0, e.dat});
                    end
                end
            end
        end
        prev_g = mon_en ? grant_o : 2'b00;
    end

    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [2:0] cti, input logic hold);
        op_t o;
        sb_t e;
        o.we = we; o.addr = addr; o.dat = we ? dat : 32'h0; o.sel = 4'hF; o.cti = cti; o.hold = hold;
        e.rd = !we; e.dat = dat;
        if (k == 0) begin mq0.push_back(o); sb0.push_back(e); end
        else        begin mq1.push_back(o); sb1.push_back(e); end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((mq0.size() + mq1.size() + sb0.size() + sb1.size()) != 0 || busy != 2'b00 || keep != 2'b00) begin
            @(posedge clk);
            n++;
            if (n > 500) break;
        end
        chk(name, n <= 500);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_grant(input string name, input logic [1:0] val);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_o !== val && n < 200);
        chk(name, grant_o === val);
    endtask

    initial begin
        int exp_ord[8];
        int base, n;
        RESETN = 1'b0;

        // 1: reset with both masters requesting.
        issue(0, 1'b1, 32'h0000_0000, 32'h1111_1111, 3'b000, 1'b0);
        issue(1, 1'b1, 32'h0000_0004, 32'h2222_2222, 3'b000, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_cyc_req", {62'h0, m_cyc}, 64'h3);
        chk_eq("rst_grant", {62'h0, grant_o}, 64'h0);
        chk_eq("rst_s_cyc", {63'h0, s_cyc_o}, 64'h0);
        chk_eq("rst_ack", {62'h0, m_ack_o}, 64'h0);
        mon_en = 1'b1;
        RESETN = 1'b1;
        wait_done("t1_done");
        chk_eq("t1_glen", glog.size(), 2);
        chk_eq("t1_first", glog[0], 0);
        chk_eq("t1_second", glog[1], 1);

        // 2: single write from master 1.
        glog.delete();
        issue(1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 3'b000, 1'b0);
        wait_grant("t2_grant", 2'b10);
        chk_eq("t2_addr", {32'h0, s_addr_o}, 64'h100);
        chk_eq("t2_dat", {32'h0, s_dat_o}, 64'hA5A5_A5A5);
        chk_eq("t2_sel", {60'h0, s_sel_o}, 64'hF);
        chk_eq("t2_we", {63'h0, s_we_o}, 64'h1);
        chk_eq("t2_no_early_ack", {62'h0, m_ack_o}, 64'h0);
        wait_done("t2_done");
        chk_eq("t2_latency", grant_cyc[1] - cyc_rise[1], 1);

        // 3: contention, 4 single writes each.
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 32'h300 + 4*i, 32'hC0 + i, 3'b000, 1'b0);
            issue(1, 1'b1, 32'h380 + 4*i, 32'hD0 + i, 3'b000, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
`ifdef SDR_ARB_PRIO_EN
            exp_ord[i] = (i < 4) ? 0 : 1;
`else
            exp_ord[i] = i % 2;
`endif
        end
        wait_done("t3_done");
        chk_eq("t3_glen", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk_eq($sformatf("t3_order_%0d", i), glog[i], exp_ord[i]);

        // 4: 8-beat burst from master 0, master 1 requests mid-burst.
        glog.delete();
        for (int i = 0; i < 8; i++)
            issue(0, 1'b1, 32'h400 + 4*i, 32'hE0 + i, (i < 7) ? 3'b010 : 3'b111, i < 7);
        wait_grant("t4_grant0", 2'b01);
        issue(1, 1'b1, 32'h0000_0480, 32'h0000_00F0, 3'b000, 1'b0);
        wait_done("t4_done");
        chk_eq("t4_glen", glog.size(), 2);
        chk_eq("t4_first", glog[0], 0);
        chk_eq("t4_second", glog[1], 1);
        chk_eq("t4_handover", grant_cyc[1] - cyc_fall[0], 2);

        // 5: readback across masters.
        issue(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 3'b000, 1'b0);
        wait_done("t5_wr");
        issue(1, 1'b0, 32'h0000_0040, 32'h1234_5678, 3'b000, 1'b0);
        wait_done("t5_rd1");
        issue(0, 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 3'b000, 1'b0);
        issue(1, 1'b0, 32'h0000_0388, 32'h0000_00D2, 3'b000, 1'b0);
        wait_done("t5_rd2");

        // Stray ack while idle must not reach any master.
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        chk_eq("stray_ack", {62'h0, m_ack_o}, 64'h0);
        chk_eq("stray_grant", {62'h0, grant_o}, 64'h0);
        stray = 1'b0;

        // 6: reset in the middle of a burst.
        base = ack_cnt[0];
        for (int i = 0; i < 8; i++)
            issue(0, 1'b1, 32'h200 + 4*i, 32'hB000_0000 + i, (i < 7) ? 3'b010 : 3'b111, i < 7);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (ack_cnt[0] - base < 3 && n < 200);
        chk("t6_three_beats", ack_cnt[0] - base >= 3);
        RESETN = 1'b0;
        abort  = 1'b1;
        sb0.delete();
        @(posedge clk);
        @(negedge clk);
        chk_eq("t6_rst_s_cyc", {63'h0, s_cyc_o}, 64'h0);
        chk_eq("t6_rst_grant", {62'h0, grant_o}, 64'h0);
        @(negedge clk);
        RESETN = 1'b1;
        glog.delete();
        issue(1, 1'b0, 32'h0000_0200, 32'hB000_0000, 3'b000, 1'b0);
        issue(1, 1'b0, 32'h0000_0204, 32'hB000_0001, 3'b000, 1'b0);
        issue(1, 1'b0, 32'h0000_0208, 32'hB000_0002, 3'b000, 1'b0);
        issue(1, 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 3'b000, 1'b0);
        issue(1, 1'b0, 32'h0000_0040, 32'h1234_5678, 3'b000, 1'b0);
        wait_done("t6_done");
        chk_eq("t6_glen", glog.size(), 5);
        chk_eq("t6_owner", glog[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
